// File: rtl/clk_divider_bank_if.sv
// Load port of the clock divider bank: one-cycle load strobe with channel index
// and new half-period, plus the registered rejection pulse.
interface clk_divider_bank_if #(
    parameter int CHB  = 2,
    parameter int CBIT = 26
);
    logic            ld;
    logic [CHB-1:0]  ld_ch;
    logic [CBIT-1:0] ld_val;
    logic            ld_err;

    modport master (output ld, ld_ch, ld_val, input  ld_err);
    modport slave  (input  ld, ld_ch, ld_val, output ld_err);
endinterface

// File: rtl/clk_divider_bank.sv
// Multi-channel programmable clock divider: per-channel 50% square wave with a
// one-cycle tick on every toggle, runtime half-period load and global re-phase.
module clk_divider_bank #(
    parameter int NCH          = 4,
    parameter int CBIT         = 26,
    parameter int DEFAULT_HALF = 25000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NCH-1:0]     en,
    input  logic               sync,
    clk_divider_bank_if.slave  ld_bus,
    output logic [NCH-1:0]     clk_div,
    output logic [NCH-1:0]     tick
);
    localparam int              CHB      = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CBIT-1:0] HALF_RST = CBIT'(DEFAULT_HALF);
    localparam logic [CHB:0]    NCH_W    = (CHB + 1)'(NCH);

    logic [CBIT-1:0] half [NCH];
    logic [CBIT-1:0] cnt  [NCH];
    logic            ld_ok;
    logic            ld_err_q;
    logic [NCH-1:0]  ld_hit;

    // Zero half-period or an out-of-range channel is rejected outright.
    always_comb begin
        ld_ok  = ld_bus.ld && (ld_bus.ld_val != '0) && ({1'b0, ld_bus.ld_ch} < NCH_W);
        ld_hit = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (ld_ok && (ld_bus.ld_ch == CHB'(i)))
                ld_hit[i] = 1'b1;
        end
    end

    assign ld_bus.ld_err = ld_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_err_q <= 1'b0;
            clk_div  <= '1;
            tick     <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                half[i] <= HALF_RST;
                cnt[i]  <= '0;
            end
        end else begin
            ld_err_q <= ld_bus.ld && !ld_ok;
            for (int unsigned i = 0; i < NCH; i++) begin
                if (ld_hit[i])
                    half[i] <= ld_bus.ld_val;
                // Priority: sync re-phase, then load restart, then counting.
                if (sync) begin
                    cnt[i]     <= '0;
                    clk_div[i] <= 1'b1;
                    tick[i]    <= 1'b0;
                end else if (ld_hit[i]) begin
                    cnt[i]  <= '0;
                    tick[i] <= 1'b0;
                end else if (en[i]) begin
                    if (cnt[i] == half[i] - CBIT'(1)) begin
                        cnt[i]     <= '0;
                        clk_div[i] <= ~clk_div[i];
                        tick[i]    <= 1'b1;
                    end else begin
                        cnt[i]  <= cnt[i] + CBIT'(1);
                        tick[i] <= 1'b0;
                    end
                end else begin
                    tick[i] <= 1'b0;
                end
            end
        end
    end
endmodule
